// File: rtl/drp_master_seq_if.sv
// drp_master_seq_if: command/response and DRP bus bundle for drp_master_seq.
//   master modport : sequencer view (takes cmd_*, returns rsp_*, drives drp*)
//   slave modport  : host + mux view (drives cmd_*, drpdo/drprdy)
// Signals:
//   cmd_valid/cmd_ready/cmd_we/cmd_int/cmd_quad/cmd_addr/cmd_wdata : command
//   rsp_valid/rsp_rdata/rsp_err                                    : response
//   drpaddr/drpdi/drpen/drpwe/int_reg/drpdo/drprdy                 : DRP to mux
interface drp_master_seq_if #(
   parameter int AW_QUAD = 9
);
   logic               cmd_valid;
   logic               cmd_ready;
   logic               cmd_we;
   logic               cmd_int;
   logic [5:0]         cmd_quad;
   logic [AW_QUAD-1:0] cmd_addr;
   logic [31:0]        cmd_wdata;
   logic               rsp_valid;
   logic [31:0]        rsp_rdata;
   logic               rsp_err;
   logic [AW_QUAD-1:0] drpaddr;
   logic [31:0]        drpdi;
   logic               drpen;
   logic               drpwe;
   logic               int_reg;
   logic [31:0]        drpdo;
   logic               drprdy;

   modport master (
      input  cmd_valid, cmd_we, cmd_int, cmd_quad, cmd_addr, cmd_wdata,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
      output drpaddr, drpdi, drpen, drpwe, int_reg,
      input  drpdo, drprdy
   );

   modport slave (
      output cmd_valid, cmd_we, cmd_int, cmd_quad, cmd_addr, cmd_wdata,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
      input  drpaddr, drpdi, drpen, drpwe, int_reg,
      output drpdo, drprdy
   );
endinterface

// File: rtl/drp_master_seq.sv
// drp_master_seq: host-side DRP sequencer for the quad DRP mux.
//   Accepts one command (quad, drp/port target, address, data, rd/wr), writes
//   the one-hot quad selector into the mux selector register (top 4 DRP
//   addresses), then performs the access and returns rdata/err.
// Ports:
//   drp_clk    : clock, rising edge
//   drp_rst_n  : synchronous reset, active low
//   bus        : drp_master_seq_if.master (cmd_*, rsp_*, drp* signals)
// Parameters: N (quads, 1..64), AW_QUAD (DRP address width), TIMEOUT (>=2).
// Build option: define DRP_SEL_CACHE_EN to skip the selector write when the
//   {cmd_int, quad} matches the last successfully written selector.
module drp_master_seq #(
   parameter int N       = 2,
   parameter int AW_QUAD = 9,
   parameter int TIMEOUT = 1023
) (
   input logic              drp_clk,
   input logic              drp_rst_n,
   drp_master_seq_if.master bus
);
   localparam int                 TW     = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0]      TMAX   = TW'(TIMEOUT);
   localparam logic [6:0]         NQ     = 7'(N);
   localparam logic [AW_QUAD-1:0] SEL_LO = {{(AW_QUAD-2){1'b1}}, 2'b00};

   typedef enum logic [2:0] {IDLE, SEL, SEL_W, ACC, ACC_W, RSP} state_t;
   state_t state, state_nx;

   logic [TW-1:0]      timer;
   logic               q_we, q_int;
   logic [5:0]         q_quad;
   logic [AW_QUAD-1:0] q_addr;
   logic [31:0]        q_wdata;
   logic [31:0]        rsp_rdata_q;
   logic               rsp_err_q;
   logic               accept, illegal, hit, waiting, tmo;

   logic               drpen_c, drpwe_c, int_reg_c;
   logic [AW_QUAD-1:0] drpaddr_c;
   logic [31:0]        drpdi_c;

   assign accept  = (state == IDLE) && bus.cmd_valid;
   assign illegal = ({1'b0, bus.cmd_quad} >= NQ) || (bus.cmd_addr >= SEL_LO);
   assign waiting = (state == SEL_W) || (state == ACC_W);
   // rdy on the cycle the timer hits TIMEOUT still wins over the abort
   assign tmo     = waiting && !bus.drprdy && (timer == TMAX);

`ifdef DRP_SEL_CACHE_EN
   logic       cache_vld;
   logic [6:0] cache_key;

   always_ff @(posedge drp_clk) begin
      if (!drp_rst_n) begin
         cache_vld <= 1'b0;
         cache_key <= '0;
      end else if (state == SEL_W && bus.drprdy) begin
         cache_vld <= 1'b1;
         cache_key <= {q_int, q_quad};
      end else if (tmo) begin
         cache_vld <= 1'b0;
      end
   end

   assign hit = cache_vld && (cache_key == {bus.cmd_int, bus.cmd_quad});
`else
   assign hit = 1'b0;
`endif

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = illegal ? RSP : (hit ? ACC : SEL);
         SEL:     state_nx = SEL_W;
         SEL_W:   if (bus.drprdy) state_nx = ACC;
                  else if (tmo)   state_nx = RSP;
         ACC:     state_nx = ACC_W;
         ACC_W:   if (bus.drprdy || tmo) state_nx = RSP;
         RSP:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      drpen_c   = 1'b0;
      drpwe_c   = 1'b0;
      drpaddr_c = '0;
      drpdi_c   = '0;
      int_reg_c = 1'b0;
      case (state)
         SEL: begin
            // low two address bits: {port/drp, lower 32 quads}
            drpen_c   = 1'b1;
            drpwe_c   = 1'b1;
            drpaddr_c = {SEL_LO[AW_QUAD-1:2], q_int, (q_quad < 6'd32)};
            drpdi_c   = 32'd1 << q_quad[4:0];
         end
         ACC: begin
            drpen_c   = 1'b1;
            drpwe_c   = q_we;
            drpaddr_c = q_addr;
            drpdi_c   = q_we ? q_wdata : '0;
            int_reg_c = q_int;
         end
         ACC_W:   int_reg_c = q_int;
         default: ;
      endcase
   end

   always_ff @(posedge drp_clk) begin
      if (!drp_rst_n) begin
         state       <= IDLE;
         timer       <= '0;
         q_we        <= 1'b0;
         q_int       <= 1'b0;
         q_quad      <= '0;
         q_addr      <= '0;
         q_wdata     <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == SEL || state == ACC) timer <= '0;
         else if (waiting)                 timer <= timer + TW'(1);
         if (accept) begin
            q_we    <= bus.cmd_we;
            q_int   <= bus.cmd_int;
            q_quad  <= bus.cmd_quad;
            q_addr  <= bus.cmd_addr;
            q_wdata <= bus.cmd_wdata;
            if (illegal) begin
               rsp_err_q   <= 1'b1;
               rsp_rdata_q <= '0;
            end
         end
         if (state == ACC_W && bus.drprdy) begin
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= q_we ? '0 : bus.drpdo;
         end else if (tmo) begin
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
         end
      end
   end

   assign bus.cmd_ready = (state == IDLE);
   assign bus.rsp_valid = (state == RSP);
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.drpen     = drpen_c;
   assign bus.drpwe     = drpwe_c;
   assign bus.drpaddr   = drpaddr_c;
   assign bus.drpdi     = drpdi_c;
   assign bus.int_reg   = int_reg_c;
endmodule

// File: tb/tb_drp_master_seq.sv
// tb_drp_master_seq: self-checking bench for drp_master_seq (N=2, AW_QUAD=9,
//   TIMEOUT=15). A mux responder answers drpen with drprdy after a chosen
//   delay; expectations come from a directed table, hand sequences and a
//   transaction-level reference model. Honors DRP_SEL_CACHE_EN.
module tb_drp_master_seq;
   localparam int NQ  = 2;
   localparam int AW  = 9;
   localparam int TMO = 15;
`ifdef DRP_SEL_CACHE_EN
   localparam bit CACHE = 1'b1;
`else
   localparam bit CACHE = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   drp_master_seq_if #(.AW_QUAD(AW)) bus();
   drp_master_seq #(.N(NQ), .AW_QUAD(AW), .TIMEOUT(TMO)) dut (
      .drp_clk(clk), .drp_rst_n(rst_n), .bus(bus)
   );

   typedef struct {
      logic [8:0]  addr;
      logic [31:0] di;
      logic        we;
      logic        ireg;
   } txn_t;

   typedef struct {
      logic        we;
      logic        in_t;
      logic [5:0]  quad;
      logic [8:0]  addr;
      logic [31:0] wdata;
      int          sdly;
      int          adly;
      bit          nordy;
      bit          exp_sel;
      logic [8:0]  sel_addr;
      logic [31:0] sel_data;
      bit          exp_acc;
      int          exp_lat;
      bit          exp_err;
      logic [31:0] exp_rdata;
   } vec_t;

   int   n_pass = 0;
   int   n_total = 0;
   txn_t obs_q[$];
   txn_t exp_q[$];
   int   sdly = 0, adly = 0;
   bit   nordy = 1'b0, stray = 1'b0;
   int   overlap = 0;
   bit   mcv = 1'b0;
   logic [6:0] mkey = '0;

   function automatic logic [31:0] rd_val(logic [8:0] a, logic i);
      return {7'h35, i, 7'h00, a, ~a[7:0]};
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Mux responder: drprdy for one cycle, 1+delay cycles after drpen.
   initial begin
      int   cnt;
      txn_t t;
      logic [31:0] pend;
      cnt = 0;
      pend = '0;
      bus.drprdy = 1'b0;
      bus.drpdo  = '0;
      forever begin
         @(posedge clk);
         #1;
         bus.drprdy = 1'b0;
         bus.drpdo  = $urandom;
         if (stray) begin
            bus.drprdy = 1'b1;
            stray = 1'b0;
         end
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               bus.drprdy = 1'b1;
               bus.drpdo  = pend;
            end
         end
         if (bus.drpen) begin
            if (cnt > 0) overlap++;
            t.addr = bus.drpaddr;
            t.di   = bus.drpdi;
            t.we   = bus.drpwe;
            t.ireg = bus.int_reg;
            obs_q.push_back(t);
            pend = bus.drpwe ? 32'h0 : rd_val(bus.drpaddr, bus.int_reg);
            if (bus.drpaddr >= 9'h1FC) cnt = 1 + sdly;
            else if (!nordy)           cnt = 1 + adly;
         end
      end
   end

   task automatic push_sel(logic [8:0] a, logic [31:0] d);
      txn_t t;
      t.addr = a; t.di = d; t.we = 1'b1; t.ireg = 1'b0;
      exp_q.push_back(t);
   endtask

   task automatic push_acc(logic we, logic i, logic [8:0] a, logic [31:0] wd);
      txn_t t;
      t.addr = a; t.di = we ? wd : 32'h0; t.we = we; t.ireg = i;
      exp_q.push_back(t);
   endtask

   task automatic start_cmd(logic we, logic i, logic [5:0] q, logic [8:0] a,
                            logic [31:0] wd);
      int k;
      k = 0;
      while (!bus.cmd_ready && k < 50) begin tick(); k++; end
      bus.cmd_we = we; bus.cmd_int = i; bus.cmd_quad = q;
      bus.cmd_addr = a; bus.cmd_wdata = wd; bus.cmd_valid = 1'b1;
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   // Latency = edges after the accept edge until rsp_valid is seen.
   task automatic issue(input logic we, input logic i, input logic [5:0] q,
                        input logic [8:0] a, input logic [31:0] wd,
                        input int sd, input int ad, input bit nr,
                        output bit got, output int lat, output bit err,
                        output logic [31:0] rd);
      sdly = sd; adly = ad; nordy = nr;
      obs_q.delete();
      start_cmd(we, i, q, a, wd);
      got = 1'b0;
      lat = 0;
      for (int k = 0; k < 80; k++) begin
         if (bus.rsp_valid) begin got = 1'b1; lat = k; break; end
         tick();
      end
      err = bus.rsp_err;
      rd  = bus.rsp_rdata;
      tick();
      if (got) chk("rsp_one_cycle", {31'h0, bus.rsp_valid}, 32'h0);
   endtask

   task automatic verify(string name, bit got, int lat, bit err, logic [31:0] rd,
                         int elat, bit eerr, logic [31:0] erd);
      int n;
      chk({name, "/rsp_seen"}, {31'h0, got}, 32'h1);
      chk({name, "/latency"}, lat, elat);
      chk({name, "/rsp_err"}, {31'h0, err}, {31'h0, eerr});
      chk({name, "/rsp_rdata"}, rd, erd);
      chk({name, "/txn_count"}, obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int j = 0; j < n; j++) begin
         chk($sformatf("%s/txn%0d_addr", name, j), {23'h0, obs_q[j].addr}, {23'h0, exp_q[j].addr});
         chk($sformatf("%s/txn%0d_di", name, j), obs_q[j].di, exp_q[j].di);
         chk($sformatf("%s/txn%0d_we_int", name, j), {30'h0, obs_q[j].we, obs_q[j].ireg},
             {30'h0, exp_q[j].we, exp_q[j].ireg});
      end
   endtask

   // Reference: selector write unless cached, then access; timeout aborts
   // after TIMEOUT+1 wait cycles without rdy and forgets the cached selector.
   task automatic model(input logic we, input logic i, input logic [5:0] q,
                        input logic [8:0] a, input logic [31:0] wd,
                        input int sd, input int ad, input bit nr,
                        output int lat, output bit err, output logic [31:0] rd);
      bit hit;
      int t;
      exp_q.delete();
      if (q >= NQ || a >= 9'h1FC) begin
         lat = 0; err = 1'b1; rd = '0;
         return;
      end
      hit = CACHE && mcv && (mkey == {i, q});
      t = 0;
      if (!hit) begin
         push_sel({7'h7F, i, (q < 6'd32)}, 32'd1 << q[4:0]);
         t = 2 + sd;
         mcv = 1'b1;
         mkey = {i, q};
      end
      push_acc(we, i, a, wd);
      if (nr || ad > TMO) begin
         lat = t + TMO + 2; err = 1'b1; rd = '0; mcv = 1'b0;
      end else begin
         lat = t + 2 + ad; err = 1'b0; rd = we ? 32'h0 : rd_val(a, i);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got no completion, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vec[9];
      bit got, err, eerr;
      int lat, elat, nv, ne;
      logic [31:0] rd, erd;

      vec[0] = '{0, 0, 6'd1, 9'h010, 32'h0, 0, 0, 0, 1, 9'h1FD, 32'h2, 1, 4, 0, rd_val(9'h010, 1'b0)};
      vec[1] = '{1, 1, 6'd0, 9'h005, 32'hA5A5, 0, 0, 0, 1, 9'h1FF, 32'h1, 1, 4, 0, 32'h0};
      vec[2] = '{0, 0, 6'd2, 9'h010, 32'h0, 0, 0, 0, 0, 9'h0, 32'h0, 0, 0, 1, 32'h0};
      vec[3] = '{0, 0, 6'd0, 9'h1FE, 32'h0, 0, 0, 0, 0, 9'h0, 32'h0, 0, 0, 1, 32'h0};
      vec[4] = '{0, 1, 6'd1, 9'h1FB, 32'h0, 2, 3, 0, 1, 9'h1FF, 32'h2, 1, 9, 0, rd_val(9'h1FB, 1'b1)};
      vec[5] = '{1, 0, 6'd0, 9'h000, 32'h12345678, 0, 15, 0, 1, 9'h1FD, 32'h1, 1, 19, 0, 32'h0};
      vec[6] = '{0, 0, 6'd1, 9'h020, 32'h0, 0, 0, 1, 1, 9'h1FD, 32'h2, 1, 19, 1, 32'h0};
      vec[7] = '{0, 0, 6'd1, 9'h020, 32'h0, 0, 0, 0, 1, 9'h1FD, 32'h2, 1, 4, 0, rd_val(9'h020, 1'b0)};
      vec[8] = '{1, 0, 6'd0, 9'h033, 32'hDEADBEEF, 0, 16, 0, 1, 9'h1FD, 32'h1, 1, 19, 1, 32'h0};

      bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_int = 1'b0;
      bus.cmd_quad = '0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
      repeat (3) tick();
      chk("reset/cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);
      chk("reset/rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
      chk("reset/rsp_err", {31'h0, bus.rsp_err}, 32'h0);
      chk("reset/rsp_rdata", bus.rsp_rdata, 32'h0);
      chk("reset/drp_ctl", {29'h0, bus.drpen, bus.drpwe, bus.int_reg}, 32'h0);
      chk("reset/drpaddr", {23'h0, bus.drpaddr}, 32'h0);
      chk("reset/drpdi", bus.drpdi, 32'h0);
      rst_n = 1'b1;
      tick();

      // Directed table: every entry is a selector miss in both builds.
      for (int i = 0; i < 9; i++) begin
         exp_q.delete();
         if (vec[i].exp_sel) push_sel(vec[i].sel_addr, vec[i].sel_data);
         if (vec[i].exp_acc) push_acc(vec[i].we, vec[i].in_t, vec[i].addr, vec[i].wdata);
         issue(vec[i].we, vec[i].in_t, vec[i].quad, vec[i].addr, vec[i].wdata,
               vec[i].sdly, vec[i].adly, vec[i].nordy, got, lat, err, rd);
         verify($sformatf("vec%0d", i), got, lat, err, rd,
                vec[i].exp_lat, vec[i].exp_err, vec[i].exp_rdata);
      end

      // Back-to-back reads of quad 1: second one hits the selector cache.
      exp_q.delete();
      push_sel(9'h1FD, 32'h2);
      push_acc(1'b0, 1'b0, 9'h010, 32'h0);
      issue(1'b0, 1'b0, 6'd1, 9'h010, 32'h0, 0, 0, 1'b0, got, lat, err, rd);
      verify("b2b_first", got, lat, err, rd, 4, 1'b0, rd_val(9'h010, 1'b0));
      exp_q.delete();
      if (!CACHE) push_sel(9'h1FD, 32'h2);
      push_acc(1'b0, 1'b0, 9'h010, 32'h0);
      elat = CACHE ? 2 : 4;
      issue(1'b0, 1'b0, 6'd1, 9'h010, 32'h0, 0, 0, 1'b0, got, lat, err, rd);
      verify("b2b_second", got, lat, err, rd, elat, 1'b0, rd_val(9'h010, 1'b0));

      // Reset while waiting for the access rdy.
      sdly = 0; adly = 0; nordy = 1'b1;
      obs_q.delete();
      start_cmd(1'b0, 1'b0, 6'd0, 9'h044, 32'h0);
      nv = 0;
      while (obs_q.size() < 2 && nv < 20) begin tick(); nv++; end
      chk("rst_mid/acc_issued", obs_q.size(), 2);
      tick();
      tick();
      chk("rst_mid/no_rsp_yet", {31'h0, bus.rsp_valid}, 32'h0);
      rst_n = 1'b0;
      tick();
      chk("rst_mid/cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);
      chk("rst_mid/rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
      chk("rst_mid/drpen", {31'h0, bus.drpen}, 32'h0);
      chk("rst_mid/rsp_rdata", bus.rsp_rdata, 32'h0);
      rst_n = 1'b1;
      nordy = 1'b0;
      stray = 1'b1;
      nv = 0;
      ne = 0;
      repeat (6) begin
         tick();
         nv += int'(bus.rsp_valid);
         ne += int'(bus.drpen);
      end
      chk("stray/rsp_valid_count", nv, 0);
      chk("stray/drpen_count", ne, 0);
      chk("stray/cmd_ready", {31'h0, bus.cmd_ready}, 32'h1);
      exp_q.delete();
      push_sel(9'h1FD, 32'h1);
      push_acc(1'b0, 1'b0, 9'h044, 32'h0);
      issue(1'b0, 1'b0, 6'd0, 9'h044, 32'h0, 0, 0, 1'b0, got, lat, err, rd);
      verify("after_reset", got, lat, err, rd, 4, 1'b0, rd_val(9'h044, 1'b0));
      mcv = 1'b1;
      mkey = 7'h00;

      // Randomized commands against the reference model.
      for (int i = 0; i < 150; i++) begin
         logic        we, in_t;
         logic [5:0]  q;
         logic [8:0]  a;
         logic [31:0] wd;
         int          sd, ad, r;
         bit          nr;
         we   = 1'($urandom_range(0, 1));
         in_t = 1'($urandom_range(0, 1));
         q    = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(2, 63)) : 6'($urandom_range(0, 1));
         a    = ($urandom_range(0, 9) == 0) ? 9'(9'h1FC + 9'($urandom_range(0, 3))) : 9'($urandom);
         wd   = $urandom;
         sd   = $urandom_range(0, 3);
         r    = $urandom_range(0, 19);
         ad   = (r < 16) ? (r % 4) : ((r == 16) ? 15 : ((r == 17) ? 16 : 0));
         nr   = (r >= 18);
         model(we, in_t, q, a, wd, sd, ad, nr, elat, eerr, erd);
         issue(we, in_t, q, a, wd, sd, ad, nr, got, lat, err, rd);
         verify($sformatf("rnd%0d", i), got, lat, err, rd, elat, eerr, erd);
      end

      chk("drpen_while_outstanding", overlap, 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
